game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 52 +++++
 rtl/game_sequencer_lfsr8.sv | 13 +
 rtl/game_sequencer.sv | 149 ++++++++++++++
 tb/tb_game_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the flappy-bird game controller.
// Scene encodings, key codes, gap/bird packing and the world-state record.
package game_pkg;

  typedef enum logic [1:0] {
    SPLASH   = 2'd0,
    PLAYING  = 2'd1,
    GAMEOVER = 2'd2
  } scene_t;

  localparam logic [7:0] KEY_SPACE = 8'd32;
  localparam logic [7:0] KEY_R     = 8'd114;
  localparam logic [7:0] KEY_X     = 8'd120;

  localparam int unsigned DEF_HEIGHT = 40;
  localparam int unsigned DEF_WIDTH  = 80;

  localparam int unsigned NUM_SLOTS     = 3;
  localparam int unsigned GAP_FIELD_W   = 8;
  localparam int unsigned GAP_SLOT_W    = 3 * GAP_FIELD_W;
  localparam int unsigned GAP_POS_LSB   = 16;
  localparam int unsigned GAP_MAX_LSB   = 8;
  localparam int unsigned GAP_MIN_LSB   = 0;
  localparam int unsigned BIRD_ALT_LSB  = 1;
  localparam int unsigned BIRD_FLAP_BIT = 0;

  typedef struct packed {
    logic [7:0] position;
    logic [7:0] max_bnd;
    logic [7:0] min_bnd;
  } gap_t;

  typedef struct packed {
    logic [7:0]                 alt;
    logic [7:0]                 flap_cnt;
    logic                       flapping;
    logic [7:0]                 tick;
    logic [7:0]                 score;
    gap_t [NUM_SLOTS-1:0]       slots;
  } world_t;

  function automatic world_t world_init();
    world_t r;
    r          = '0;
    r.alt      = 8'd20;
    r.slots[0] = '{position: 8'd20, max_bnd: 8'd30, min_bnd: 8'd20};
    r.slots[1] = '{position: 8'd40, max_bnd: 8'd25, min_bnd: 8'd15};
    r.slots[2] = '{position: 8'd60, max_bnd: 8'd35, min_bnd: 8'd25};
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset only.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= 8'hA5;
    else     state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule

// File: rtl/game_sequencer.sv
// Scene FSM, bird physics, pipe scrolling/respawn, collision and score.
// Optional accelerating fall is enabled by defining GRAVITY_ACCEL_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned HEIGHT      = DEF_HEIGHT,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned FLAP_LEN    = 5,
  parameter int unsigned GAP_SIZE    = 10,
  parameter int unsigned RESPAWN_POS = 60,
  parameter int unsigned BIRD_COL    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inp,
  output logic [1:0]  scene,
  output logic [8:0]  bird,
  output logic [71:0] gaps,
  output logic [7:0]  score
);

  localparam logic [7:0] H_MAX     = 8'(HEIGHT - 1);
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] FLAP8     = 8'(FLAP_LEN);
  localparam logic [7:0] GAP8      = 8'(GAP_SIZE);
  localparam logic [7:0] RESP8     = 8'(RESPAWN_POS);
  localparam logic [7:0] PASS_POS  = 8'(BIRD_COL);
  localparam logic [7:0] REACH     = 8'(BIRD_COL + 6);
  localparam logic [7:0] OFF_WRAP  = 8'(HEIGHT - GAP_SIZE - 3);

  scene_t     scene_q;
  world_t     w, w_nx;
  logic [7:0] lfsr_state;
  logic       unused_lfsr_hi;
  logic [7:0] off, resp_min, resp_max;
  logic       step, passed, collide;

  lfsr8 u_lfsr (.clk(clk), .rst(rst), .state(lfsr_state));
  assign unused_lfsr_hi = ^lfsr_state[7:5];

  assign step = (w.tick == TICK_LAST);

`ifdef GRAVITY_ACCEL_EN
  logic [1:0] vel, vel_nx;
  always_comb begin
    vel_nx = vel;
    if (step && w.flap_cnt == '0 && vel != 2'd3) vel_nx = vel + 2'd1;
    if (inp == KEY_SPACE) vel_nx = 2'd1;
  end
`endif

  always_comb begin
    off = {3'b000, lfsr_state[4:0]};
    if (off >= OFF_WRAP) off = off - OFF_WRAP;
    resp_min = 8'd2 + off;
    resp_max = resp_min + GAP8;
  end

  always_comb begin
    collide = 1'b0;
    if (scene_q == PLAYING) begin
      if (w.alt == '0) collide = 1'b1;
      for (int unsigned i = 0; i < NUM_SLOTS; i++)
        if (w.slots[i].position <= REACH &&
            (w.alt <= w.slots[i].min_bnd || w.alt >= w.slots[i].max_bnd))
          collide = 1'b1;
    end
  end

  // Altitude direction uses the pre-edge flap count, so a press landing on a
  // step edge reloads the counter without also consuming a climb.
  always_comb begin
    w_nx   = w;
    passed = 1'b0;
    w_nx.tick = step ? '0 : w.tick + 8'd1;
    if (step) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (w.slots[i].position == '0) begin
          w_nx.slots[i] = '{position: RESP8, max_bnd: resp_max, min_bnd: resp_min};
        end else begin
          w_nx.slots[i].position = w.slots[i].position - 8'd1;
          if (w.slots[i].position == PASS_POS) passed = 1'b1;
        end
      end
      if (w.flap_cnt != '0)
        w_nx.alt = (w.alt >= H_MAX) ? H_MAX : w.alt + 8'd1;
      else
`ifdef GRAVITY_ACCEL_EN
        w_nx.alt = (w.alt > {6'b0, vel}) ? w.alt - {6'b0, vel} : '0;
`else
        w_nx.alt = (w.alt == '0) ? '0 : w.alt - 8'd1;
`endif
      if (passed && w.score != '1) w_nx.score = w.score + 8'd1;
    end
    if (inp == KEY_SPACE) begin
      w_nx.flap_cnt = FLAP8;
      w_nx.flapping = (FLAP8 != '0);
    end else if (step && w.flap_cnt != '0) begin
      w_nx.flap_cnt = w.flap_cnt - 8'd1;
      w_nx.flapping = (w.flap_cnt != 8'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene_q <= SPLASH;
      w       <= world_init();
`ifdef GRAVITY_ACCEL_EN
      vel     <= 2'd1;
`endif
    end else begin
      case (scene_q)
        SPLASH: begin
          w <= world_init();
`ifdef GRAVITY_ACCEL_EN
          vel <= 2'd1;
`endif
          if (inp != '0) scene_q <= PLAYING;
        end
        PLAYING: begin
          if (collide || inp == KEY_X) begin
            scene_q <= GAMEOVER;
          end else begin
            w <= w_nx;
`ifdef GRAVITY_ACCEL_EN
            vel <= vel_nx;
`endif
          end
        end
        GAMEOVER: begin
          if (inp == KEY_R) begin
            scene_q <= SPLASH;
            w       <= world_init();
`ifdef GRAVITY_ACCEL_EN
            vel     <= 2'd1;
`endif
          end
        end
        default: scene_q <= SPLASH;
      endcase
    end
  end

  assign scene = scene_q;
  assign bird  = {w.alt, w.flapping};
  assign gaps  = {w.slots[0], w.slots[1], w.slots[2]};
  assign score = w.score;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scoreboard bench for game_sequencer: expectations are queued as
// stimulus is driven and compared once the corresponding clocks have elapsed.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inp = '0;
  logic [1:0]  scene;
  logic [8:0]  bird;
  logic [71:0] gaps;
  logic [7:0]  score;

  localparam logic [71:0] GAPS_INIT =
    {8'd20, 8'd30, 8'd20, 8'd40, 8'd25, 8'd15, 8'd60, 8'd35, 8'd25};

  localparam int K_SCENE = 0, K_BIRD = 1, K_GAPS = 2, K_SCORE = 3,
                 K_POS0 = 4, K_LEGAL0 = 5;

  game_sequencer #(
    .HEIGHT(40), .TICK_DIV(4), .FLAP_LEN(5), .GAP_SIZE(10),
    .RESPAWN_POS(60), .BIRD_COL(2)
  ) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .scene(scene), .bird(bird), .gaps(gaps), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [71:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [71:0] observe(input int kind);
    logic [71:0] r;
    logic [7:0]  mn, mx;
    r  = '0;
    mn = gaps[55:48];
    mx = gaps[63:56];
    case (kind)
      K_SCENE:  r = {70'b0, scene};
      K_BIRD:   r = {63'b0, bird};
      K_GAPS:   r = gaps;
      K_SCORE:  r = {64'b0, score};
      K_POS0:   r = {64'b0, gaps[71:64]};
      K_LEGAL0: r = {71'b0, (mn >= 8'd2 && mn <= 8'd28 && mx == mn + 8'd10)};
      default:  r = 'x;
    endcase
    return r;
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [71:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [71:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [7:0] k);
    inp = k;
    clocks(1);
    inp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    rst = 1'b1;
    expect_val("rst_scene", K_SCENE, 72'd0);
    expect_val("rst_bird",  K_BIRD,  72'h028);
    expect_val("rst_gaps",  K_GAPS,  GAPS_INIT);
    expect_val("rst_score", K_SCORE, 72'd0);
    clocks(2);
    check_all();
    rst = 1'b0;
    expect_val("splash_idle", K_SCENE, 72'd0);
    clocks(3);
    check_all();

    // splash exit and free fall into the first pipe
    expect_val("enter_scene", K_SCENE, 72'd1);
    expect_val("enter_bird",  K_BIRD,  72'h028);
    key(8'd65);
    check_all();
    expect_val("fall1_bird", K_BIRD, 72'h026);
    expect_val("fall1_pos0", K_POS0, 72'd19);
    clocks(4);
    check_all();
    expect_val("fall12_bird",  K_BIRD,  72'h010);
    expect_val("fall12_pos0",  K_POS0,  72'd8);
    expect_val("fall12_scene", K_SCENE, 72'd1);
    clocks(44);
    check_all();
    expect_val("crash_scene", K_SCENE, 72'd2);
    clocks(1);
    check_all();
    expect_val("frozen_bird",  K_BIRD,  72'h010);
    expect_val("frozen_scene", K_SCENE, 72'd2);
    clocks(1);
    check_all();

    // GAMEOVER ignores other keys, 'r' restarts
    expect_val("q_ignored", K_SCENE, 72'd2);
    key(8'd113);
    check_all();
    expect_val("r_scene", K_SCENE, 72'd0);
    expect_val("r_bird",  K_BIRD,  72'h028);
    expect_val("r_gaps",  K_GAPS,  GAPS_INIT);
    expect_val("r_score", K_SCORE, 72'd0);
    key(8'd114);
    check_all();
    expect_val("replay_scene", K_SCENE, 72'd1);
    expect_val("replay_bird",  K_BIRD,  72'h028);
    key(8'd65);
    check_all();

    // flap: climb 5 steps, then fall
    expect_val("flap_start", K_BIRD, 72'h029);
    key(8'd32);
    check_all();
    expect_val("flap_top", K_BIRD, 72'h032);
    clocks(19);
    check_all();
    expect_val("flap_fall", K_BIRD, 72'h030);
    expect_val("flap_pos0", K_POS0, 72'd14);
    clocks(4);
    check_all();

    // steer through slot0 gap, score on pass, respawn at 0
    clocks(8);
    key(8'd32);
    expect_val("thread_bird", K_BIRD, 72'h030);
    expect_val("thread_pos0", K_POS0, 72'd4);
    clocks(31);
    check_all();
    expect_val("reflap_bird", K_BIRD, 72'h031);
    key(8'd32);
    check_all();
    expect_val("pass_score", K_SCORE, 72'd1);
    expect_val("pass_pos0",  K_POS0,  72'd1);
    expect_val("pass_bird",  K_BIRD,  72'h037);
    clocks(11);
    check_all();
    expect_val("edge_pos0",  K_POS0,  72'd0);
    expect_val("edge_score", K_SCORE, 72'd1);
    expect_val("edge_bird",  K_BIRD,  72'h039);
    clocks(4);
    check_all();
    expect_val("respawn_pos0",  K_POS0,   72'd60);
    expect_val("respawn_legal", K_LEGAL0, 72'd1);
    expect_val("respawn_scene", K_SCENE,  72'd1);
    expect_val("respawn_bird",  K_BIRD,   72'h03a);
    expect_val("respawn_score", K_SCORE,  72'd1);
    clocks(4);
    check_all();

    // quit and restart
    expect_val("quit_scene", K_SCENE, 72'd2);
    key(8'd120);
    check_all();
    expect_val("restart_scene", K_SCENE, 72'd0);
    expect_val("restart_gaps",  K_GAPS,  GAPS_INIT);
    expect_val("restart_score", K_SCORE, 72'd0);
    key(8'd114);
    check_all();

    // asynchronous reset mid-game
    key(8'd65);
    expect_val("pre_rst_bird", K_BIRD, 72'h026);
    clocks(6);
    check_all();
    rst = 1'b1;
    #2;
    expect_val("async_scene", K_SCENE, 72'd0);
    expect_val("async_bird",  K_BIRD,  72'h028);
    expect_val("async_gaps",  K_GAPS,  GAPS_INIT);
    expect_val("async_score", K_SCORE, 72'd0);
    check_all();
    clocks(1);
    rst = 1'b0;
    expect_val("post_rst_scene", K_SCENE, 72'd0);
    clocks(1);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
